cv32e40p_obi_resp_delay_fifo: RTL and testbench

//  Parametrised OBI response model for the memory side of the testbench.
//  - Records every granted request (req_i && gnt_i) in order.
//  - Captures read data one cycle after the grant.
//  - Returns responses in order, each one delayed by a per-entry stall count
//    (off, fixed, or LFSR-random).
//  - Fully synthesisable and Verilator-clean; no $urandom anywhere.

---
 rtl/cv32e40p_obi_resp_delay_pkg.sv | 20 ++
 rtl/cv32e40p_obi_resp_delay_lfsr.sv | 27 ++
 rtl/cv32e40p_obi_resp_delay_fifo.sv | 153 +++++++++++++++
 tb/tb_cv32e40p_obi_resp_delay_fifo.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_obi_resp_delay_pkg.sv
// Shared types and helpers for the OBI response delay FIFO.
// Holds the stall mode encoding and the 16-bit Galois LFSR step function.
package cv32e40p_obi_resp_delay_pkg;

  typedef enum logic [1:0] {
    STALL_OFF      = 2'd0,
    STALL_STANDARD = 2'd1,
    STALL_RANDOM   = 2'd2
  } stall_mode_e;

  localparam int unsigned LFSR_W = 16;

  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    lfsr_step = {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/cv32e40p_obi_resp_delay_lfsr.sv
// 16-bit Galois LFSR that steps only when en_i is high.
// Reset loads seed_i, which is expected to be a constant tie-off.
module cv32e40p_obi_resp_delay_lfsr
  import cv32e40p_obi_resp_delay_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              en_i,
  output logic [LFSR_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= seed_i;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/cv32e40p_obi_resp_delay_fifo.sv
// In-order OBI response model with per-entry stall delays (off/fixed/LFSR).
// Define OBI_RESP_ERR_EN to store err_i and return it on err_o.
module cv32e40p_obi_resp_delay_fifo
  import cv32e40p_obi_resp_delay_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DELAY_W   = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  input  logic                     gnt_i,
  input  logic                     we_i,
  input  logic [DATA_W-1:0]        rdata_i,
  input  logic                     err_i,
  input  logic                     en_stall_i,
  input  logic [1:0]               stall_mode_i,
  input  logic [DELAY_W-1:0]       max_stall_i,
  input  logic [DELAY_W-1:0]       valid_stall_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     err_o,
  output logic                     rvalid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   outstanding_o,
  output logic                     overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic               we;
    logic [DELAY_W-1:0] delay;
`ifdef OBI_RESP_ERR_EN
    logic               err;
`endif
    logic [DATA_W-1:0]  data;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic              cap_vld_q, cap_vld_d;
  logic [AW-1:0]     cap_idx_q, cap_idx_d;
  logic              ovf_q, ovf_d;

  logic [LFSR_W-1:0]  lfsr;
  logic [AW-1:0]      waddr, raddr;
  logic               empty, full, push, pop, bypass;
  logic [DELAY_W-1:0] push_delay, rnd_delay;
  logic [DATA_W-1:0]  cap_data;
  entry_t             head;
  logic               lfsr_unused;

  assign waddr  = wptr_q[AW-1:0];
  assign raddr  = rptr_q[AW-1:0];
  assign empty  = (wptr_q == rptr_q);
  assign full   = (waddr == raddr) && (wptr_q[AW] != rptr_q[AW]);
  assign push   = req_i && gnt_i && !full;
  assign head   = mem_q[raddr];
  assign pop    = !empty && (head.delay == '0);
  // The head may still be waiting for its read data; forward it straight through.
  assign bypass = cap_vld_q && (cap_idx_q == raddr);
  assign cap_data = mem_q[cap_idx_q].we ? '0 : rdata_i;

  cv32e40p_obi_resp_delay_lfsr u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .seed_i (LFSR_SEED),
    .en_i   (push),
    .lfsr_o (lfsr)
  );

  assign lfsr_unused = ^lfsr[LFSR_W-1:DELAY_W];
  assign rnd_delay   = (lfsr[DELAY_W-1:0] < max_stall_i) ? lfsr[DELAY_W-1:0] : max_stall_i;

  always_comb begin
    push_delay = '0;
    if (en_stall_i) begin
      case (stall_mode_i)
        STALL_STANDARD: push_delay = valid_stall_i;
        STALL_RANDOM:   push_delay = rnd_delay;
        default:        push_delay = '0;
      endcase
    end
  end

  always_comb begin
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cap_vld_d = 1'b0;
    cap_idx_d = cap_idx_q;
    ovf_d     = ovf_q || (req_i && gnt_i && full);

    if (cap_vld_q) begin
      mem_d[cap_idx_q].data = cap_data;
`ifdef OBI_RESP_ERR_EN
      mem_d[cap_idx_q].err  = err_i;
`endif
    end

    // Only the head counts down, so queued entries stall back to back.
    if (!empty && (head.delay != '0))
      mem_d[raddr].delay = head.delay - DELAY_W'(1);

    if (pop) rptr_d = rptr_q + PW'(1);

    if (push) begin
      mem_d[waddr]       = '0;
      mem_d[waddr].we    = we_i;
      mem_d[waddr].delay = push_delay;
      wptr_d             = wptr_q + PW'(1);
      cap_vld_d          = 1'b1;
      cap_idx_d          = waddr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign rvalid_o      = pop;
  assign rdata_o       = pop ? (bypass ? cap_data : head.data) : '0;
  assign full_o        = full;
  assign outstanding_o = wptr_q - rptr_q;
  assign overflow_o    = ovf_q;

`ifdef OBI_RESP_ERR_EN
  assign err_o = pop && (bypass ? err_i : head.err);
`else
  logic err_unused;
  assign err_unused = err_i;
  assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40p_obi_resp_delay_fifo.sv
// Bench for the OBI response delay FIFO: a response-time model
// (due = max(push+1, prev_due+1) + delay) checked every cycle, plus directed literals.
module tb_cv32e40p_obi_resp_delay_fifo;

  localparam int          DATA_W  = 32;
  localparam int          DEPTH   = 8;
  localparam int          DELAY_W = 4;
  localparam logic [15:0] SEED    = 16'hACE1;
`ifdef OBI_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk_i = 1'b0, rst_ni = 1'b0;
  logic              req_i = 1'b0, gnt_i = 1'b0, we_i = 1'b0, err_i = 1'b0;
  logic [DATA_W-1:0] rdata_i = '0;
  logic              en_stall_i = 1'b0;
  logic [1:0]        stall_mode_i = 2'd0;
  logic [DELAY_W-1:0] max_stall_i = '0, valid_stall_i = '0;
  logic [DATA_W-1:0] rdata_o;
  logic              err_o, rvalid_o, full_o, overflow_o;
  logic [3:0]        outstanding_o;

  cv32e40p_obi_resp_delay_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .DELAY_W(DELAY_W), .LFSR_SEED(SEED)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_i(gnt_i), .we_i(we_i),
    .rdata_i(rdata_i), .err_i(err_i), .en_stall_i(en_stall_i),
    .stall_mode_i(stall_mode_i), .max_stall_i(max_stall_i),
    .valid_stall_i(valid_stall_i), .rdata_o(rdata_o), .err_o(err_o),
    .rvalid_o(rvalid_o), .full_o(full_o), .outstanding_o(outstanding_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_run = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: each response is due when it reaches the head plus its own delay.
  typedef struct {
    int                due;
    logic              we;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t        mq[$];
  int          last_due;
  bit          m_ovf, cap_pend;
  logic [15:0] m_lfsr;
  int          rv_cyc[$];
  logic [31:0] rv_data[$];
  logic        rv_err[$];

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    // Divide by x^16+x^14+x^13+x^11+1, one bit per step, shifting right.
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[15] = ~n[15]; n[13] = ~n[13]; n[12] = ~n[12]; n[10] = ~n[10];
    end
    return n;
  endfunction

  function automatic int model_delay();
    int lo;
    if (!en_stall_i) return 0;
    case (stall_mode_i)
      2'd1: return int'(valid_stall_i);
      2'd2: begin
        lo = int'(m_lfsr[DELAY_W-1:0]);
        return (lo < int'(max_stall_i)) ? lo : int'(max_stall_i);
      end
      default: return 0;
    endcase
  endfunction

  always @(negedge clk_i) begin
    int   sz, d;
    exp_t e;
    if (!rst_ni) begin
      mq.delete(); last_due = -1; m_ovf = 0; cap_pend = 0; m_lfsr = SEED;
      chk("rst_rvalid", rvalid_o, 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_outstanding", outstanding_o, 0);
      chk("rst_overflow", overflow_o, 0);
    end else begin
      if (cap_pend) begin
        e = mq[mq.size()-1];
        e.data = e.we ? '0 : rdata_i;
        e.err  = ERR_EN ? err_i : 1'b0;
        mq[mq.size()-1] = e;
        cap_pend = 0;
      end
      sz = mq.size();
      chk("outstanding", outstanding_o, sz);
      chk("full", full_o, sz == DEPTH);
      chk("overflow", overflow_o, m_ovf);
      if (sz > 0 && mq[0].due == cyc) begin
        chk("rvalid", rvalid_o, 1);
        chk("rdata", rdata_o, mq[0].data);
        chk("err", err_o, mq[0].err);
        rv_cyc.push_back(cyc); rv_data.push_back(rdata_o); rv_err.push_back(err_o);
        void'(mq.pop_front());
      end else begin
        chk("rvalid_idle", rvalid_o, 0);
        chk("rdata_idle", rdata_o, 0);
        chk("err_idle", err_o, 0);
      end
      if (req_i && gnt_i) begin
        if (sz == DEPTH) m_ovf = 1;
        else begin
          d = model_delay();
          e.due  = ((cyc + 1 > last_due + 1) ? cyc + 1 : last_due + 1) + d;
          e.we   = we_i; e.data = '0; e.err = 1'b0;
          mq.push_back(e);
          last_due = e.due; cap_pend = 1;
          m_lfsr = lfsr_adv(m_lfsr);
        end
      end
    end
  end

  task automatic drv(input logic r, input logic g, input logic w,
                     input logic [31:0] d, input logic er);
    req_i = r; gnt_i = g; we_i = w; rdata_i = d; err_i = er;
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 32'h0, 0);
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((mq.size() != 0 || cap_pend) && k < 400) begin idle(1); k++; end
    chk({nm, "_drain_in_time"}, k < 400, 1);
    idle(2);
  endtask

  task automatic do_reset();
    req_i = 0; gnt_i = 0;
    rst_ni = 1'b0; #1;
    chk("async_rst_rvalid", rvalid_o, 0);
    chk("async_rst_outstanding", outstanding_o, 0);
    idle(2);
    rst_ni = 1'b1;
    idle(1);
  endtask

  task automatic clr_log();
    rv_cyc.delete(); rv_data.delete(); rv_err.delete();
  endtask

  task automatic set_mode(input logic en, input logic [1:0] m, input logic [3:0] v,
                          input logic [3:0] mx);
    en_stall_i = en; stall_mode_i = m; valid_stall_i = v; max_stall_i = mx;
  endtask

  int dly[2][100];

  task automatic rand_run(input int r);
    int g, k;
    set_mode(1, 2'd2, 4'd0, 4'd5);
    clr_log();
    for (int i = 0; i < 100; i++) begin
      g = cyc;
      drv(1, 1, 0, 32'h0, 0);
      drv(0, 0, 0, 32'h100 + i, 0);
      k = 0;
      while (rv_cyc.size() < i + 1 && k < 20) begin idle(1); k++; end
      if (rv_cyc.size() < i + 1) begin
        chk("rand_timeout", 0, 1);
        dly[r][i] = 99;
      end else dly[r][i] = rv_cyc[i] - g - 1;
    end
    drain("rand");
  endtask

  initial begin
    int g, bad;
    do_reset();

    // 1: OFF mode, back-to-back reads
    set_mode(0, 2'd0, 4'd0, 4'd0);
    clr_log();
    g = cyc;
    drv(1, 1, 0, 32'h0, 0);
    drv(1, 1, 0, 32'hA0, 0);
    drv(1, 1, 0, 32'hA1, 0);
    drv(1, 1, 0, 32'hA2, 0);
    drv(0, 0, 0, 32'hA3, 0);
    drain("off");
    chk("off_count", rv_cyc.size(), 4);
    for (int i = 0; i < 4 && i < rv_cyc.size(); i++) begin
      chk("off_cycle", rv_cyc[i], g + 1 + i);
      chk("off_data", rv_data[i], 32'hA0 + i);
    end

    // 2: STANDARD delay 3, single then pair
    set_mode(1, 2'd1, 4'd3, 4'd0);
    clr_log();
    g = cyc;
    drv(1, 1, 0, 32'h0, 0);
    drv(0, 0, 0, 32'hB0, 0);
    drain("std1");
    chk("std1_latency", (rv_cyc.size() > 0) ? rv_cyc[0] - g : -1, 4);
    clr_log();
    g = cyc;
    drv(1, 1, 0, 32'h0, 0);
    drv(1, 1, 0, 32'hB1, 0);
    drv(0, 0, 0, 32'hB2, 0);
    drain("std2");
    chk("std2_count", rv_cyc.size(), 2);
    if (rv_cyc.size() == 2) begin
      chk("std2_first", rv_cyc[0] - g, 4);
      chk("std2_gap", rv_cyc[1] - rv_cyc[0], 4);
      chk("std2_data1", rv_data[1], 32'hB2);
    end

    // 3: fill with delay 15, then overflow
    set_mode(1, 2'd1, 4'd15, 4'd0);
    clr_log();
    drv(1, 1, 0, 32'h0, 0);
    for (int i = 0; i < 7; i++) drv(1, 1, 0, 32'hC0 + i, 0);
    chk("fill_full", full_o, 1);
    chk("fill_outstanding", outstanding_o, 8);
    chk("fill_no_ovf_yet", overflow_o, 0);
    drv(1, 1, 0, 32'hC7, 0);
    chk("ovf_set", overflow_o, 1);
    chk("ovf_outstanding", outstanding_o, 8);
    drain("fill");
    chk("fill_resp_count", rv_cyc.size(), 8);
    chk("ovf_sticky", overflow_o, 1);

    // 4: RANDOM, two identical runs from reset
    do_reset();
    chk("ovf_cleared", overflow_o, 0);
    rand_run(0);
    do_reset();
    rand_run(1);
    chk("rand_pin0", dly[0][0], 1);
    chk("rand_pin1", dly[0][1], 0);
    chk("rand_pin2", dly[0][2], 5);
    bad = 0;
    for (int i = 0; i < 100; i++) if (dly[0][i] < 0 || dly[0][i] > 5) bad++;
    chk("rand_range_bad", bad, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) if (dly[0][i] != dly[1][i]) bad++;
    chk("rand_repeat_bad", bad, 0);

    // 5: write then read, err on the read
    set_mode(0, 2'd0, 4'd0, 4'd0);
    clr_log();
    drv(1, 1, 1, 32'h0, 0);
    drv(1, 1, 0, 32'hDEAD, 0);
    drv(0, 0, 0, 32'h1234, 1);
    drain("wr_rd");
    chk("wr_rd_count", rv_cyc.size(), 2);
    if (rv_cyc.size() == 2) begin
      chk("wr_data", rv_data[0], 32'h0);
      chk("rd_data", rv_data[1], 32'h1234);
      chk("wr_err", rv_err[0], 0);
      chk("rd_err", rv_err[1], ERR_EN);
    end

    // 6: reset with entries mid-delay
    set_mode(1, 2'd1, 4'd15, 4'd0);
    clr_log();
    drv(1, 1, 0, 32'h0, 0);
    drv(1, 1, 0, 32'hE0, 0);
    drv(1, 1, 0, 32'hE1, 0);
    drv(0, 0, 0, 32'hE2, 0);
    idle(4);
    chk("pre_rst_outstanding", outstanding_o, 3);
    do_reset();
    set_mode(0, 2'd0, 4'd0, 4'd0);
    clr_log();
    g = cyc;
    drv(1, 1, 0, 32'h0, 0);
    drv(0, 0, 0, 32'h55, 0);
    drain("post_rst");
    chk("post_rst_count", rv_cyc.size(), 1);
    if (rv_cyc.size() == 1) begin
      chk("post_rst_cycle", rv_cyc[0], g + 1);
      chk("post_rst_data", rv_data[0], 32'h55);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
